// File: rtl/q_sys_desc_pkg.sv
// Shared types and constants for the q_sys descriptor fetcher: FSM states,
// descriptor word offsets, control-word bit positions and error codes.
package q_sys_desc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CHECK,
    ST_PRESENT,
    ST_WB
  } desc_state_t;

  localparam int WORD_SRC  = 0;
  localparam int WORD_DST  = 1;
  localparam int WORD_CTRL = 2;
  localparam int WORD_NEXT = 3;

  localparam int BIT_OWNED = 31;
  localparam int BIT_EOC   = 30;
  localparam int BIT_IRQ   = 29;

  localparam int LEN_W = 24;

  localparam logic [1:0] ERR_NONE       = 2'b00;
  localparam logic [1:0] ERR_MISALIGNED = 2'b01;
  localparam logic [1:0] ERR_MAX_CHAIN  = 2'b10;

endpackage

// File: rtl/q_sys_desc_word_capture.sv
// Descriptor word capture: delays the issued read offset by the RAM latency
// and stores each returning word into its slot of a 4-word register file.
module q_sys_desc_word_capture #(
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rd_en,
  input  logic [1:0]             rd_off,
  input  logic [DATA_W-1:0]      rd_data,
  output logic [3:0][DATA_W-1:0] words
);

  logic       cap_en;
  logic [1:0] cap_off;

  // Read data returns one cycle after its address, so the offset travels one stage behind it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cap_en  <= 1'b0;
      cap_off <= 2'b00;
      words   <= '0;
    end else begin
      cap_en  <= rd_en;
      cap_off <= rd_off;
      if (cap_en) begin
        words[cap_off] <= rd_data;
      end
    end
  end

endmodule

// File: rtl/q_sys_descriptor_fetcher.sv
// Walks a linked chain of 4-word DMA descriptors in the descriptor RAM and presents
// hardware-owned ones downstream. Define Q_SYS_DESC_WRITEBACK_EN to clear OWNED after each handshake.
module q_sys_descriptor_fetcher
  import q_sys_desc_pkg::*;
#(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MAX_CHAIN = 512
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_ptr,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic [DATA_W-1:0] mem_writedata,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic              desc_valid,
  input  logic              desc_ready,
  output logic [DATA_W-1:0] desc_src,
  output logic [DATA_W-1:0] desc_dst,
  output logic [LEN_W-1:0]  desc_len,
  output logic              desc_irq,
  output logic [9:0]        desc_count
);

  desc_state_t            state;
  logic [2:0]             fetch_cnt;
  logic [3:0][DATA_W-1:0] words;
  logic [DATA_W-1:0]      ctrl;
  logic [ADDR_W-1:0]      next_ptr;
  logic                   exit_now;
  logic                   unused_bits;

  q_sys_desc_word_capture #(
    .DATA_W (DATA_W)
  ) u_capture (
    .clk     (clk),
    .reset_n (reset_n),
    .rd_en   (mem_chipselect & ~mem_write),
    .rd_off  (mem_address[1:0]),
    .rd_data (mem_readdata),
    .words   (words)
  );

  assign ctrl        = words[WORD_CTRL];
  assign next_ptr    = words[WORD_NEXT][ADDR_W-1:0];
  assign desc_src    = words[WORD_SRC];
  assign desc_dst    = words[WORD_DST];
  assign desc_len    = ctrl[LEN_W-1:0];
  assign desc_irq    = ctrl[BIT_IRQ];
  assign unused_bits = ^{words[WORD_NEXT][DATA_W-1:ADDR_W], ctrl[BIT_IRQ-1:LEN_W]};

`ifdef Q_SYS_DESC_WRITEBACK_EN
  assign exit_now = (state == ST_WB);
`else
  assign exit_now = (state == ST_PRESENT) && desc_ready;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_writedata  = '0;
`endif

  // Single FSM; abort pre-empts everything, and the chain exit decision is shared by PRESENT/WB.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      fetch_cnt      <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      err_code       <= ERR_NONE;
      mem_address    <= '0;
      mem_chipselect <= 1'b0;
      desc_valid     <= 1'b0;
      desc_count     <= '0;
`ifdef Q_SYS_DESC_WRITEBACK_EN
      mem_write      <= 1'b0;
      mem_byteenable <= 4'hF;
      mem_writedata  <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        state          <= ST_IDLE;
        busy           <= 1'b0;
        desc_valid     <= 1'b0;
        mem_chipselect <= 1'b0;
`ifdef Q_SYS_DESC_WRITEBACK_EN
        mem_write      <= 1'b0;
        mem_byteenable <= 4'hF;
`endif
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (start_ptr[1:0] != 2'b00) begin
                error    <= 1'b1;
                err_code <= ERR_MISALIGNED;
              end else begin
                mem_address    <= start_ptr;
                mem_chipselect <= 1'b1;
                fetch_cnt      <= '0;
                desc_count     <= '0;
                error          <= 1'b0;
                err_code       <= ERR_NONE;
                busy           <= 1'b1;
                state          <= ST_FETCH;
              end
            end
          end
          ST_FETCH: begin
            fetch_cnt <= fetch_cnt + 3'd1;
            if (fetch_cnt < 3'd3) begin
              mem_address <= mem_address + ADDR_W'(1);
            end else begin
              mem_chipselect <= 1'b0;
            end
            if (fetch_cnt == 3'd4) begin
              state <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (!ctrl[BIT_OWNED]) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end else if (desc_count == 10'(MAX_CHAIN)) begin
              error    <= 1'b1;
              err_code <= ERR_MAX_CHAIN;
              busy     <= 1'b0;
              state    <= ST_IDLE;
            end else begin
              desc_valid <= 1'b1;
              state      <= ST_PRESENT;
            end
          end
          ST_PRESENT: begin
            if (desc_ready) begin
              desc_valid <= 1'b0;
              desc_count <= desc_count + 10'd1;
`ifdef Q_SYS_DESC_WRITEBACK_EN
              // mem_address still holds P+3 from the fetch, so the control word sits one below it.
              mem_address    <= mem_address - ADDR_W'(1);
              mem_chipselect <= 1'b1;
              mem_write      <= 1'b1;
              mem_byteenable <= 4'b1000;
              mem_writedata  <= ctrl & ~(DATA_W'(1) << BIT_OWNED);
              state          <= ST_WB;
`endif
            end
          end
`ifdef Q_SYS_DESC_WRITEBACK_EN
          ST_WB: begin
            mem_write      <= 1'b0;
            mem_byteenable <= 4'hF;
            mem_chipselect <= 1'b0;
          end
`endif
          default: state <= ST_IDLE;
        endcase

        if (exit_now) begin
          if (ctrl[BIT_EOC]) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (next_ptr[1:0] != 2'b00) begin
            error    <= 1'b1;
            err_code <= ERR_MISALIGNED;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            mem_address    <= next_ptr;
            mem_chipselect <= 1'b1;
            fetch_cnt      <= '0;
            state          <= ST_FETCH;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_q_sys_descriptor_fetcher.sv
// Self-checking bench for q_sys_descriptor_fetcher: chain-walk model plus directed scenarios.
// Expectations follow Q_SYS_DESC_WRITEBACK_EN when it is defined for the build.
module tb_q_sys_descriptor_fetcher;

  localparam int ADDR_W    = 11;
  localparam int MAX_CHAIN = 4;
  localparam int LIMIT     = 400;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_ptr = '0;
  logic              abort = 1'b0;
  logic              busy, done, error;
  logic [1:0]        err_code;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect, mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata, mem_readdata;
  logic              desc_valid;
  logic              desc_ready = 1'b1;
  logic [31:0]       desc_src, desc_dst;
  logic [23:0]       desc_len;
  logic              desc_irq;
  logic [9:0]        desc_count;

  always #5 clk = ~clk;

  q_sys_descriptor_fetcher #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (32),
    .MAX_CHAIN (MAX_CHAIN)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start          (start),
    .start_ptr      (start_ptr),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .err_code       (err_code),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .desc_valid     (desc_valid),
    .desc_ready     (desc_ready),
    .desc_src       (desc_src),
    .desc_dst       (desc_dst),
    .desc_len       (desc_len),
    .desc_irq       (desc_irq),
    .desc_count     (desc_count)
  );

  // Descriptor RAM: registered address, unregistered read data, byte-enabled writes
  logic [31:0]       ram [2048];
  logic [ADDR_W-1:0] rd_addr = '0;

  always @(posedge clk) begin
    if (mem_chipselect) begin
      rd_addr <= mem_address;
      if (mem_write) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
      end
    end
  end
  assign mem_readdata = ram[rd_addr];

  int checks = 0;
  int failures = 0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s actual=event required=no_event", name);
  endtask

  // Chain model: walks a snapshot of the RAM following the descriptor rules
  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [23:0] len;
    logic        irq;
  } exp_desc_t;

  exp_desc_t         exp_desc_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [ADDR_W-1:0] exp_wb_addr_q[$];
  logic [31:0]       exp_wb_data_q[$];
  logic [31:0]       mram [2048];
  int                exp_hs;
  int                exp_end;
  int                hs_seen = 0;
  int                wr_seen = 0;

  task automatic build_model(input logic [ADDR_W-1:0] first);
    logic [ADDR_W-1:0] p;
    logic [31:0]       w2;
    int                n;
    exp_desc_q.delete();
    exp_addr_q.delete();
    exp_wb_addr_q.delete();
    exp_wb_data_q.delete();
    for (int i = 0; i < 2048; i++) mram[i] = ram[i];
    n = 0;
    p = first;
    exp_end = 0;
    if (p[1:0] != 2'b00) begin
      exp_end = 1;
    end else begin
      forever begin
        for (int k = 0; k < 4; k++) exp_addr_q.push_back(p + ADDR_W'(k));
        w2 = mram[p + 11'd2];
        if (!w2[31]) begin exp_end = 0; break; end
        if (n == MAX_CHAIN) begin exp_end = 2; break; end
        exp_desc_q.push_back('{mram[p], mram[p + 11'd1], w2[23:0], w2[29]});
        n++;
`ifdef Q_SYS_DESC_WRITEBACK_EN
        exp_wb_addr_q.push_back(p + 11'd2);
        exp_wb_data_q.push_back(w2 & 32'h7FFF_FFFF);
        mram[p + 11'd2][31] = 1'b0;
`endif
        if (w2[30]) begin exp_end = 0; break; end
        if (mram[p + 11'd3][1:0] != 2'b00) begin exp_end = 1; break; end
        p = mram[p + 11'd3][ADDR_W-1:0];
      end
    end
    exp_hs = n;
  endtask

  // Compare process: bus reads/writes and presented descriptors against the model every cycle
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_chipselect && !mem_write) begin
        if (exp_addr_q.size() == 0) report_fail("unexpected_read");
        else check_output("rd_addr", 32'(mem_address), 32'(exp_addr_q.pop_front()));
      end
`ifdef Q_SYS_DESC_WRITEBACK_EN
      if (mem_chipselect && mem_write) begin
        wr_seen++;
        if (exp_wb_addr_q.size() == 0) report_fail("unexpected_write");
        else begin
          check_output("wb_addr", 32'(mem_address), 32'(exp_wb_addr_q.pop_front()));
          check_output("wb_data", mem_writedata, exp_wb_data_q.pop_front());
          check_output("wb_be", 32'(mem_byteenable), 32'h8);
        end
      end
`else
      if (mem_write) wr_seen++;
      check_output("mem_write_low", 32'(mem_write), 32'h0);
`endif
      if (desc_valid) begin
        if (exp_desc_q.size() == 0) report_fail("unexpected_desc");
        else begin
          check_output("desc_src", desc_src, exp_desc_q[0].src);
          check_output("desc_dst", desc_dst, exp_desc_q[0].dst);
          check_output("desc_len", 32'(desc_len), 32'(exp_desc_q[0].len));
          check_output("desc_irq", 32'(desc_irq), 32'(exp_desc_q[0].irq));
          check_output("desc_count_live", 32'(desc_count), 32'(hs_seen));
          if (desc_ready && !abort) begin
            void'(exp_desc_q.pop_front());
            hs_seen++;
          end
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [ADDR_W-1:0] p);
    build_model(p);
    hs_seen = 0;
    start_ptr = p;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name, output int cycles);
    cycles = 0;
    while (busy && cycles < LIMIT) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (busy) begin
      report_fail(name);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
    end
  endtask

  task automatic set_desc(input int p, input logic [31:0] s, input logic [31:0] d,
                          input logic [31:0] c, input logic [31:0] nx);
    ram[p] = s;
    ram[p + 1] = d;
    ram[p + 2] = c;
    ram[p + 3] = nx;
  endtask

  initial begin
    int cyc;
    logic seen;
    logic [31:0] held_src, held_len;

    for (int i = 0; i < 2048; i++) ram[i] = 32'h0;
    set_desc(0,    32'h1000_0000, 32'h2000_0000, 32'h8000_0100, 32'd4);
    set_desc(4,    32'h1000_1000, 32'h2000_1000, 32'hA000_0200, 32'd8);
    set_desc(8,    32'h1000_2000, 32'h2000_2000, 32'hC000_0300, 32'd0);
    set_desc(16,   32'h1111_0000, 32'h2222_0000, 32'h4000_0050, 32'd20);
    set_desc(20,   32'h1000_3000, 32'h2000_3000, 32'h8000_0010, 32'd9);
    set_desc(2044, 32'h1000_4000, 32'h2000_4000, 32'h8000_0020, 32'd2044);
    set_desc(24,   32'h1000_5000, 32'h2000_5000, 32'hC000_0040, 32'd0);
    set_desc(28,   32'h1000_6000, 32'h2000_6000, 32'hC000_0060, 32'd0);
    set_desc(32,   32'h1000_7000, 32'h2000_7000, 32'h8000_0080, 32'd36);
    set_desc(36,   32'h1000_8000, 32'h2000_8000, 32'hC000_0090, 32'd0);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_busy", 32'(busy), 32'h0);
    check_output("rst_done", 32'(done), 32'h0);
    check_output("rst_error", 32'(error), 32'h0);
    check_output("rst_err_code", 32'(err_code), 32'h0);
    check_output("rst_desc_valid", 32'(desc_valid), 32'h0);
    check_output("rst_chipselect", 32'(mem_chipselect), 32'h0);
    check_output("rst_write", 32'(mem_write), 32'h0);
    check_output("rst_byteenable", 32'(mem_byteenable), 32'hF);
    check_output("rst_desc_count", 32'(desc_count), 32'h0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] scenario 1: chain of three at 0,4,8");
    apply_stimulus(11'd0);
    check_output("model_src0", exp_desc_q[0].src, 32'h1000_0000);
    check_output("model_irq1", 32'(exp_desc_q[1].irq), 32'h1);
    check_output("model_hs1", 32'(exp_hs), 32'd3);
    check_output("t1_busy_start", 32'(busy), 32'h1);
    wait_idle("t1_timeout", cyc);
    check_output("t1_done", 32'(done), 32'h1);
    check_output("t1_handshakes", 32'(hs_seen), 32'd3);
    check_output("t1_desc_count", 32'(desc_count), 32'd3);
    check_output("t1_error", 32'(error), 32'h0);
    @(posedge clk);
    #1;
    check_output("t1_done_pulse", 32'(done), 32'h0);

    $display("[TB] scenario 2: descriptor not owned");
    apply_stimulus(11'd16);
    wait_idle("t2_timeout", cyc);
    check_output("t2_done_latency", 32'(cyc), 32'd6);
    check_output("t2_done", 32'(done), 32'h1);
    check_output("t2_error", 32'(error), 32'h0);
    check_output("t2_handshakes", 32'(hs_seen), 32'd0);

    $display("[TB] scenario 3: misaligned pointers");
    apply_stimulus(11'd5);
    seen = busy;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      seen = seen | busy;
    end
    check_output("t3_busy_never", 32'(seen), 32'h0);
    check_output("t3_error", 32'(error), 32'h1);
    check_output("t3_err_code", 32'(err_code), 32'h1);
    apply_stimulus(11'd20);
    check_output("t3b_error_cleared", 32'(error), 32'h0);
    wait_idle("t3b_timeout", cyc);
    check_output("t3b_handshakes", 32'(hs_seen), 32'd1);
    check_output("t3b_error", 32'(error), 32'h1);
    check_output("t3b_err_code", 32'(err_code), 32'h1);
    check_output("t3b_done", 32'(done), 32'h0);

    $display("[TB] scenario 4: self-loop at top of RAM");
    apply_stimulus(11'd2044);
    wait_idle("t4_timeout", cyc);
`ifdef Q_SYS_DESC_WRITEBACK_EN
    check_output("t4_handshakes", 32'(hs_seen), 32'd1);
    check_output("t4_done", 32'(done), 32'h1);
    check_output("t4_error", 32'(error), 32'h0);
`else
    check_output("t4_handshakes", 32'(hs_seen), 32'd4);
    check_output("t4_error", 32'(error), 32'h1);
    check_output("t4_err_code", 32'(err_code), 32'h2);
    check_output("t4_desc_count", 32'(desc_count), 32'd4);
`endif
    check_output("t4_reads_consumed", 32'(exp_addr_q.size()), 32'd0);

    $display("[TB] scenario 5: stalled consumer then abort");
    desc_ready = 1'b0;
    apply_stimulus(11'd24);
    cyc = 0;
    while (!desc_valid && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_output("t5_valid_seen", 32'(desc_valid), 32'h1);
    held_src = desc_src;
    held_len = 32'(desc_len);
    for (int i = 1; i <= 20; i++) begin
      if (i == 10) begin
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_output("t5_valid_after_abort", 32'(desc_valid), 32'h0);
        check_output("t5_busy_after_abort", 32'(busy), 32'h0);
        check_output("t5_done_after_abort", 32'(done), 32'h0);
        check_output("t5_error_after_abort", 32'(error), 32'h0);
        check_output("t5_cs_after_abort", 32'(mem_chipselect), 32'h0);
      end else begin
        @(posedge clk);
        #1;
        if (i < 10) begin
          check_output("t5_src_stable", desc_src, held_src);
          check_output("t5_len_stable", 32'(desc_len), held_len);
          check_output("t5_valid_held", 32'(desc_valid), 32'h1);
        end else begin
          check_output("t5_valid_stays_low", 32'(desc_valid), 32'h0);
        end
      end
    end
    desc_ready = 1'b1;
    apply_stimulus(11'd28);
    check_output("t5_restart_busy", 32'(busy), 32'h1);
    wait_idle("t5_restart_timeout", cyc);
    check_output("t5_restart_done", 32'(done), 32'h1);
    check_output("t5_restart_handshakes", 32'(hs_seen), 32'd1);

    $display("[TB] scenario 6: OWNED write-back on chain of two");
    wr_seen = 0;
    apply_stimulus(11'd32);
    wait_idle("t6_timeout", cyc);
    check_output("t6_done", 32'(done), 32'h1);
    check_output("t6_handshakes", 32'(hs_seen), 32'd2);
`ifdef Q_SYS_DESC_WRITEBACK_EN
    check_output("t6_writes", 32'(wr_seen), 32'd2);
    check_output("t6_owned0", 32'(ram[34][31]), 32'h0);
    check_output("t6_owned1", 32'(ram[38][31]), 32'h0);
    check_output("t6_ctrl0", ram[34], 32'h0000_0080);
`else
    check_output("t6_writes", 32'(wr_seen), 32'd0);
    check_output("t6_ctrl0_untouched", ram[34], 32'h8000_0080);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
